stack: RTL and testbench
========================

Name: stack

Overview:
- Synchronous LIFO stack: parameterised word width and depth, registered read port, Full/Empty status flags.
- Used as a small push-down store in datapath and lab designs.
- Single clock domain, one push or one pop per clock edge.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 8, number of storage entries (power of two, ≥ 2).
- PTR_W, $clog2(DEPTH), width of the internal stack pointer; the occupancy counter is PTR_W+1 bits.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- RstN  input  1  asynchronous active-low reset.
- Data_In  input  WIDTH  word to push.
- Push  input  1  push request, sampled on the rising edge.
- Pop  input  1  pop request, sampled on the rising edge.
- Data_Out  output  WIDTH  registered word popped most recently.
- Full  output  1  high when occupancy == DEPTH.
- Empty  output  1  high when occupancy == 0.

Behaviour:
- Reset (RstN low, asynchronous, regardless of Clk): occupancy = 0, Data_Out = 0, Empty = 1, Full = 0. Memory contents need not be cleared. Reset asserted mid-operation discards all entries immediately.
- Internal state: memory array mem[0..DEPTH-1], occupancy count cnt (0..DEPTH). Top of stack is mem[cnt-1].
- Push only (Push=1, Pop=0), not Full: mem[cnt] <= Data_In, cnt <= cnt+1. Data_Out holds its value.
- Push only while Full: ignored. No write, cnt unchanged, no wrap-around, existing data preserved.
- Pop only (Pop=1, Push=0), not Empty: Data_Out <= mem[cnt-1], cnt <= cnt-1. One-cycle latency: the value is visible after the edge.
- Pop only while Empty: ignored. Data_Out holds its previous value, cnt stays 0.
- Push=1 and Pop=1 in the same cycle: no operation. cnt, memory and Data_Out are all unchanged, in every occupancy state.
- Neither asserted: all state held.
- Full and Empty are decoded from the registered cnt, so they update in the same cycle as the count change. They are never both high.
- No handshake beyond the flags: the caller must check Full/Empty. Illegal requests are silently dropped.

Optional Feature:
- Macro: STACK_PEEK_EN.
- Defined: Data_Out is combinational top-of-stack, mem[cnt-1] when cnt > 0, else 0. It reflects a push in the cycle after the push edge. A pop still decrements cnt; after the pop, Data_Out shows the new top.
- Not defined: Data_Out is the registered pop-result port described in Behaviour.

Test Plan:
- Reset: drive RstN=0 with Push=1 → Empty=1, Full=0, Data_Out=0, no write occurs. Release RstN, then check flags are unchanged.
- Basic LIFO: push 4'hF, push 4'hD, pop → Data_Out=4'hD, Empty=0 (one entry, 4'hF, remains).
- Fill to full: from that state push 6,7,E,4,2,8,6 → Full=1 after the 7th push. Further pushes 7,E,2 are ignored and Full stays 1.
- Drain: 8 consecutive pops → Data_Out sequence 6,8,2,4,E,7,6,F. Empty=1 after the 8th pop, Full=0 after the 1st pop.
- Underflow: one more pop while Empty → Data_Out stays 4'hF, Empty stays 1.
- Simultaneous: Push=1, Pop=1, Data_In=0 when empty → nothing changes. Repeat with 3 entries stored → cnt, top entry and Data_Out all unchanged.

Source files
------------

// File: rtl/stack.sv
// Synchronous LIFO stack with Full/Empty flags and a registered pop-result port.
// Optional STACK_PEEK_EN: Data_Out becomes a combinational top-of-stack view.
module stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Push,
  input  logic             Pop,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Full,
  output logic             Empty
);

  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_idx, top_idx;
  logic             push_ok, pop_ok;

  assign Full  = (cnt_q == CntFull);
  assign Empty = (cnt_q == '0);

  // Simultaneous push and pop is defined as a no-op, not a replace.
  assign push_ok = Push & ~Pop & ~Full;
  assign pop_ok  = Pop & ~Push & ~Empty;

  // When full the low pointer bits wrap to 0, so top_idx still lands on DEPTH-1.
  assign wr_idx  = cnt_q[PTR_W-1:0];
  assign top_idx = cnt_q[PTR_W-1:0] - PtrOne;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok) begin
      cnt_d = cnt_q + CntOne;
    end else if (pop_ok) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= Data_In;
    end
  end

`ifdef STACK_PEEK_EN
  assign Data_Out = Empty ? '0 : mem_q[top_idx];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      dout_q <= '0;
    end else if (pop_ok) begin
      dout_q <= mem_q[top_idx];
    end
  end

  assign Data_Out = dout_q;
`endif

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack (default build): directed vector table,
// hand-written reset/simultaneous sequences, and random traffic against a queue model.
module tb_stack;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int total;
  int bad;

  stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .Clk     (clk),
    .RstN    (rst_n),
    .Data_In (data_in),
    .Push    (push),
    .Pop     (pop),
    .Data_Out(data_out),
    .Full    (full),
    .Empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_full;
    logic             exp_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] d,
                            input logic f, input logic e);
    check({tag, ".dout"}, 32'(data_out), 32'(d));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic pu, input logic po, input logic [WIDTH-1:0] d);
    push    = pu;
    pop     = po;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic pu, input logic po, input logic [WIDTH-1:0] d,
                              input logic [WIDTH-1:0] ed, input logic ef, input logic ee);
    vec_t v;
    v.push = pu; v.pop = po; v.din = d;
    v.exp_dout = ed; v.exp_full = ef; v.exp_empty = ee;
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_dout;
    logic [WIDTH-1:0] pop_seq[8];
    logic [WIDTH-1:0] fill_seq[7];
    int               bias;

    total = 0;
    bad   = 0;
    push = 1'b0; pop = 1'b0; data_in = '0;

    // Reset with Push held high: no write, flags at reset values.
    rst_n   = 1'b0;
    push    = 1'b1;
    data_in = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 4'h0, 1'b0, 1'b1);
    push  = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    check_outs("post_reset", 4'h0, 1'b0, 1'b1);

    // Directed LIFO sequence from basic push/pop through fill, drain, underflow.
    fill_seq = '{4'h6, 4'h7, 4'hE, 4'h4, 4'h2, 4'h8, 4'h6};
    pop_seq  = '{4'h6, 4'h8, 4'h2, 4'h4, 4'hE, 4'h7, 4'h6, 4'hF};
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hD, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4'hD, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, fill_seq[i], 4'hD, (i == 6), 0));
    vecs.push_back(mk(1, 0, 4'h7, 4'hD, 1, 0));
    vecs.push_back(mk(1, 0, 4'hE, 4'hD, 1, 0));
    vecs.push_back(mk(1, 0, 4'h2, 4'hD, 1, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 4'h0, pop_seq[i], 0, (i == 7)));
    vecs.push_back(mk(0, 1, 4'h0, 4'hF, 0, 1));
    vecs.push_back(mk(1, 1, 4'h0, 4'hF, 0, 1));

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_empty);
    end

    // Simultaneous push+pop with 3 entries: count, top and Data_Out untouched.
    step(1, 0, 4'h1);
    step(1, 0, 4'h2);
    step(1, 0, 4'h3);
    step(1, 1, 4'h9);
    check_outs("sim3", 4'hF, 1'b0, 1'b0);
    step(0, 1, 4'h0);
    check_outs("sim3_pop1", 4'h3, 1'b0, 1'b0);
    step(0, 1, 4'h0);
    check_outs("sim3_pop2", 4'h2, 1'b0, 1'b0);
    step(0, 1, 4'h0);
    check_outs("sim3_pop3", 4'h1, 1'b0, 1'b1);

    // Asynchronous reset mid-operation, asserted between clock edges.
    step(1, 0, 4'h5);
    step(1, 0, 4'h6);
    step(0, 1, 4'h0);
    check_outs("pre_async", 4'h6, 1'b0, 1'b0);
    push = 1'b0; pop = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 4'h0);
    check_outs("async_pop", 4'h0, 1'b0, 1'b1);

    // Random traffic against a queue model; bias rotates to hit both full and empty.
    model_q.delete();
    model_dout = 4'h0;
    for (int n = 0; n < 600; n++) begin
      logic             pu, po;
      logic [WIDTH-1:0] d;
      bias = ((n / 60) % 2 == 0) ? 75 : 25;
      pu = ($urandom_range(0, 99) < bias);
      po = ($urandom_range(0, 99) < (100 - bias));
      d  = WIDTH'($urandom_range(0, 15));
      step(pu, po, d);
      if (pu && !po && model_q.size() < DEPTH) begin
        model_q.push_back(d);
      end else if (po && !pu && model_q.size() > 0) begin
        model_dout = model_q.pop_back();
      end
      check_outs($sformatf("rnd%0d", n), model_dout, (model_q.size() == DEPTH),
                 (model_q.size() == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
